char_select_menu: RTL and testbench

CHAR_SELECT_MENU -- requirements
Module: char_select_menu

---
 rtl/divekick_pkg.sv | 20 ++
 rtl/key_edge_detect.sv | 22 ++
 rtl/char_select_menu.sv | 177 +++++++++++++++++
 tb/tb_char_select_menu.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/divekick_pkg.sv
// Shared types and constants for the character-select menu.
// Key indices are offsets within each player's four-key group.
package divekick_pkg;

  typedef enum logic [1:0] {
    ST_SELECT    = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_FIGHT     = 2'd2
  } menu_state_e;

  localparam int NUM_CHARS_DEFAULT = 4;
  localparam int CHAR_NUM_W        = 4;

  localparam int KEYS_PER_PLAYER = 4;
  localparam int KEY_LEFT        = 0;
  localparam int KEY_RIGHT       = 1;
  localparam int KEY_CONFIRM     = 2;
  localparam int KEY_CANCEL      = 3;

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for one key level: press is high for the single
// cycle in which the key is first seen high.
module key_edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic key_i,
  output logic press_o
);

  logic prev_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= key_i;
    end
  end

  assign press_o = key_i & ~prev_q;

endmodule

// File: rtl/char_select_menu.sv
// Two-player character-select menu: cursor/lock per player, then a
// frame-counted countdown that launches the fight.
module char_select_menu
  import divekick_pkg::*;
#(
  parameter int NUM_CHARS        = NUM_CHARS_DEFAULT,
  parameter int COUNTDOWN_FRAMES = 60
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Frame_Tick,
  input  logic                  P1_Left,
  input  logic                  P1_Right,
  input  logic                  P1_Confirm,
  input  logic                  P1_Cancel,
  input  logic                  P2_Left,
  input  logic                  P2_Right,
  input  logic                  P2_Confirm,
  input  logic                  P2_Cancel,
  input  logic                  Fight_Over,
  output logic [CHAR_NUM_W-1:0] Player_One_Char_Num,
  output logic [CHAR_NUM_W-1:0] Player_Two_Char_Num,
  output logic                  P1_Locked,
  output logic                  P2_Locked,
  output logic [1:0]            Menu_State,
  output logic [7:0]            Countdown_Value,
  output logic                  Start_Fight
);

  logic [2*KEYS_PER_PLAYER-1:0] key_lvl;
  logic [2*KEYS_PER_PLAYER-1:0] key_press;
  logic [1:0]                   cancel_press;

  menu_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        start_q, start_d;

  assign key_lvl = {P2_Cancel, P2_Confirm, P2_Right, P2_Left,
                    P1_Cancel, P1_Confirm, P1_Right, P1_Left};

  genvar gi;
  generate
    for (gi = 0; gi < 2*KEYS_PER_PLAYER; gi++) begin : g_edge
      key_edge_detect u_edge (
        .Clk     (Clk),
        .Reset   (Reset),
        .key_i   (key_lvl[gi]),
        .press_o (key_press[gi])
      );
    end
  endgenerate

  assign cancel_press = {key_press[KEYS_PER_PLAYER + KEY_CANCEL], key_press[KEY_CANCEL]};

  // Simultaneous left and right cancel out; both directions wrap.
  function automatic logic [CHAR_NUM_W-1:0] step_char(input logic [CHAR_NUM_W-1:0] cur,
                                                      input logic dec, input logic inc);
    logic [CHAR_NUM_W-1:0] last;
    last      = CHAR_NUM_W'(NUM_CHARS - 1);
    step_char = cur;
    if (inc && !dec) begin
      step_char = (cur == last) ? '0 : cur + 1'b1;
    end else if (dec && !inc) begin
      step_char = (cur == '0) ? last : cur - 1'b1;
    end
  endfunction

  generate
    for (gi = 0; gi < 2; gi++) begin : g_player
      logic [CHAR_NUM_W-1:0] char_q, char_d;
      logic                  lock_q, lock_d;
      logic                  left, right, confirm, cancel;

      assign left    = key_press[gi*KEYS_PER_PLAYER + KEY_LEFT];
      assign right   = key_press[gi*KEYS_PER_PLAYER + KEY_RIGHT];
      assign confirm = key_press[gi*KEYS_PER_PLAYER + KEY_CONFIRM];
      assign cancel  = key_press[gi*KEYS_PER_PLAYER + KEY_CANCEL];

      always_comb begin
        char_d = char_q;
        lock_d = lock_q;
        case (state_q)
          ST_SELECT: begin
            if (!lock_q) begin
              char_d = step_char(char_q, left, right);
            end
            if (confirm && !cancel) begin
              lock_d = 1'b1;
            end else if (cancel && !confirm) begin
              lock_d = 1'b0;
            end
          end
          ST_COUNTDOWN: begin
            if (cancel) begin
              lock_d = 1'b0;
            end
          end
          ST_FIGHT: begin
            if (Fight_Over) begin
              lock_d = 1'b0;
            end
          end
          default: ;
        endcase
      end

      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          char_q <= '0;
          lock_q <= 1'b0;
        end else begin
          char_q <= char_d;
          lock_q <= lock_d;
        end
      end
    end
  endgenerate

  // Cancel outranks a final frame tick arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    case (state_q)
      ST_SELECT: begin
        if (g_player[0].lock_d && g_player[1].lock_d) begin
          state_d = ST_COUNTDOWN;
          cnt_d   = 8'(COUNTDOWN_FRAMES);
        end
      end
      ST_COUNTDOWN: begin
        if (|cancel_press) begin
          state_d = ST_SELECT;
          cnt_d   = '0;
        end else if (Frame_Tick) begin
          if (cnt_q <= 8'd1) begin
            state_d = ST_FIGHT;
            cnt_d   = '0;
            start_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      ST_FIGHT: begin
        if (Fight_Over) begin
          state_d = ST_SELECT;
        end
      end
      default: begin
        state_d = ST_SELECT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_SELECT;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  assign Player_One_Char_Num = g_player[0].char_q;
  assign Player_Two_Char_Num = g_player[1].char_q;
  assign P1_Locked           = g_player[0].lock_q;
  assign P2_Locked           = g_player[1].lock_q;
  assign Menu_State          = state_q;
  assign Countdown_Value     = cnt_q;
  assign Start_Fight         = start_q;

endmodule

// File: tb/tb_char_select_menu.sv
// Self-checking bench for char_select_menu: directed scenarios followed by
// random key/tick traffic compared against a behavioural model.
module tb_char_select_menu;

  localparam int N = 4;
  localparam int F = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Frame_Tick = 1'b0;
  logic       Fight_Over = 1'b0;
  // bit p*4+k : player p, key k (0 left, 1 right, 2 confirm, 3 cancel)
  logic [7:0] keys = '0;

  logic [3:0] Player_One_Char_Num, Player_Two_Char_Num;
  logic       P1_Locked, P2_Locked, Start_Fight;
  logic [1:0] Menu_State;
  logic [7:0] Countdown_Value;

  always #5 Clk = ~Clk;

  char_select_menu #(.NUM_CHARS(N), .COUNTDOWN_FRAMES(F)) dut (
    .Clk                 (Clk),
    .Reset               (Reset),
    .Frame_Tick          (Frame_Tick),
    .P1_Left             (keys[0]),
    .P1_Right            (keys[1]),
    .P1_Confirm          (keys[2]),
    .P1_Cancel           (keys[3]),
    .P2_Left             (keys[4]),
    .P2_Right            (keys[5]),
    .P2_Confirm          (keys[6]),
    .P2_Cancel           (keys[7]),
    .Fight_Over          (Fight_Over),
    .Player_One_Char_Num (Player_One_Char_Num),
    .Player_Two_Char_Num (Player_Two_Char_Num),
    .P1_Locked           (P1_Locked),
    .P2_Locked           (P2_Locked),
    .Menu_State          (Menu_State),
    .Countdown_Value     (Countdown_Value),
    .Start_Fight         (Start_Fight)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: menu phase 0 select, 1 countdown, 2 fight.
  int m_c[2];
  int m_lk[2];
  int m_phase, m_cnt, m_start;
  bit prevk[8];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_c[0] = 0; m_c[1] = 0;
    m_lk[0] = 0; m_lk[1] = 0;
    m_phase = 0; m_cnt = 0; m_start = 0;
    for (int i = 0; i < 8; i++) prevk[i] = 1'b0;
  endtask

  task automatic model_edge();
    int pr[8];
    for (int i = 0; i < 8; i++) begin
      pr[i] = (keys[i] && !prevk[i]) ? 1 : 0;
      prevk[i] = keys[i];
    end
    m_start = 0;
    if (m_phase == 0) begin
      for (int p = 0; p < 2; p++) begin
        if (m_lk[p] == 0) m_c[p] = (m_c[p] + pr[p*4+1] - pr[p*4] + N) % N;
        if (pr[p*4+2] == 1 && pr[p*4+3] == 0) m_lk[p] = 1;
        else if (pr[p*4+3] == 1 && pr[p*4+2] == 0) m_lk[p] = 0;
      end
      if (m_lk[0] == 1 && m_lk[1] == 1) begin
        m_phase = 1;
        m_cnt   = F;
      end
    end else if (m_phase == 1) begin
      if (pr[3] == 1 || pr[7] == 1) begin
        if (pr[3] == 1) m_lk[0] = 0;
        if (pr[7] == 1) m_lk[1] = 0;
        m_phase = 0;
        m_cnt   = 0;
      end else if (Frame_Tick) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_phase = 2;
          m_start = 1;
        end
      end
    end else if (Fight_Over) begin
      m_phase = 0;
      m_lk[0] = 0;
      m_lk[1] = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ":p1_char"}, Player_One_Char_Num, m_c[0]);
    chk({tag, ":p2_char"}, Player_Two_Char_Num, m_c[1]);
    chk({tag, ":p1_lock"}, P1_Locked, m_lk[0]);
    chk({tag, ":p2_lock"}, P2_Locked, m_lk[1]);
    chk({tag, ":state"}, Menu_State, m_phase);
    chk({tag, ":count"}, Countdown_Value, m_cnt);
    chk({tag, ":start"}, Start_Fight, m_start);
  endtask

  // Inputs are driven at posedge+1; the model and DUT both consume them at the next edge.
  task automatic step(input string tag);
    model_edge();
    @(posedge Clk);
    #1;
    compare_all(tag);
  endtask

  // Reset is asserted and released between clock edges; outputs must clear at once.
  task automatic apply_reset(input string tag);
    #2;
    Reset = 1'b1;
    #1;
    chk({tag, ":rst_p1c"}, Player_One_Char_Num, 0);
    chk({tag, ":rst_p2c"}, Player_Two_Char_Num, 0);
    chk({tag, ":rst_lk1"}, P1_Locked, 0);
    chk({tag, ":rst_lk2"}, P2_Locked, 0);
    chk({tag, ":rst_state"}, Menu_State, 0);
    chk({tag, ":rst_cnt"}, Countdown_Value, 0);
    chk({tag, ":rst_start"}, Start_Fight, 0);
    model_reset();
    @(posedge Clk);
    #1;
    compare_all({tag, ":held"});
    Reset = 1'b0;
  endtask

  int exp_seq[5];

  initial begin
    exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 0; exp_seq[4] = 1;
    model_reset();
    @(posedge Clk);
    #1;
    apply_reset("init");
    $display("txn reset: outputs cleared");

    // P1 right x5 wraps through 0; P2 untouched
    for (int i = 0; i < 5; i++) begin
      keys[1] = 1'b1;
      step("p1_right");
      chk("p1_right_seq", Player_One_Char_Num, exp_seq[i]);
      chk("p2_idle", Player_Two_Char_Num, 0);
      keys[1] = 1'b0;
      step("p1_release");
    end
    $display("txn p1 right x5: p1_char=%0d", Player_One_Char_Num);

    // P2 holds left: one press only
    keys[4] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step("p2_hold_left");
      chk("p2_hold_val", Player_Two_Char_Num, 3);
    end
    keys[4] = 1'b0;
    step("p2_release");
    $display("txn p2 hold left: p2_char=%0d", Player_Two_Char_Num);

    // both confirm, full countdown
    keys[2] = 1'b1; keys[6] = 1'b1;
    step("lock_both");
    chk("cd_load", Countdown_Value, F);
    chk("cd_state", Menu_State, 1);
    keys = '0;
    step("lock_release");
    for (int k = 0; k < F; k++) begin
      Frame_Tick = 1'b1;
      step("tick");
      Frame_Tick = 1'b0;
      chk("cd_value", Countdown_Value, F - 1 - k);
      chk("cd_start_pulse", Start_Fight, (k == F - 1) ? 1 : 0);
      step("tick_gap");
      chk("start_one_cycle", Start_Fight, 0);
    end
    chk("fight_state", Menu_State, 2);
    $display("txn countdown: state=%0d", Menu_State);

    // fight freezes keys; fight_over returns to select
    keys[1] = 1'b1; keys[3] = 1'b1;
    step("fight_keys");
    keys = '0;
    step("fight_keys_rel");
    chk("fight_frozen_char", Player_One_Char_Num, 1);
    chk("fight_frozen_lock", P1_Locked, 1);
    Fight_Over = 1'b1;
    step("fight_over");
    Fight_Over = 1'b0;
    chk("fo_state", Menu_State, 0);
    chk("fo_lk1", P1_Locked, 0);
    chk("fo_lk2", P2_Locked, 0);
    chk("fo_c1", Player_One_Char_Num, 1);
    chk("fo_c2", Player_Two_Char_Num, 3);
    $display("txn fight over: state=%0d", Menu_State);

    // cancel beats final tick
    keys[2] = 1'b1; keys[6] = 1'b1;
    step("relock");
    keys = '0;
    for (int k = 0; k < F - 1; k++) begin
      Frame_Tick = 1'b1;
      step("pre_tick");
      Frame_Tick = 1'b0;
      step("pre_gap");
    end
    chk("cd_at_one", Countdown_Value, 1);
    keys[3] = 1'b1; Frame_Tick = 1'b1;
    step("cancel_vs_tick");
    keys = '0; Frame_Tick = 1'b0;
    chk("cxl_state", Menu_State, 0);
    chk("cxl_lk1", P1_Locked, 0);
    chk("cxl_lk2", P2_Locked, 1);
    chk("cxl_start", Start_Fight, 0);
    step("cxl_after");
    chk("cxl_no_start", Start_Fight, 0);
    $display("txn cancel vs final tick: state=%0d", Menu_State);

    // async reset mid-countdown, with P1 right held through release
    keys[2] = 1'b1;
    step("p1_relock");
    keys = '0;
    Frame_Tick = 1'b1;
    step("mid_tick");
    Frame_Tick = 1'b0;
    keys[1] = 1'b1;
    apply_reset("mid_cd");
    step("held_through_rst");
    chk("held_press", Player_One_Char_Num, 1);
    step("held_still");
    chk("held_once", Player_One_Char_Num, 1);
    keys = '0;
    step("held_release");
    $display("txn reset mid countdown: p1_char=%0d", Player_One_Char_Num);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, ((b % 4) == 3) ? 15 : 3) == 0) keys[b] = ~keys[b];
      end
      Frame_Tick = ($urandom_range(0, 2) == 0);
      Fight_Over = ($urandom_range(0, 15) == 0);
      if (i == 1500) begin
        apply_reset("rnd_rst");
      end
      step("rnd");
      if ((i % 500) == 499) $display("txn random block %0d: state=%0d", i / 500, Menu_State);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
